// File: rtl/otter_pkg.sv
// Shared OTTER decode types: opcodes, SYSTEM funct3, select codes and the control bundle.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic {ST_RUN, ST_TRAP} trap_state_t;

  localparam logic [2:0] PCS_PLUS4  = 3'd0;
  localparam logic [2:0] PCS_JALR   = 3'd1;
  localparam logic [2:0] PCS_BRANCH = 3'd2;
  localparam logic [2:0] PCS_JAL    = 3'd3;
  localparam logic [2:0] PCS_INTR   = 3'd4;
  localparam logic [2:0] PCS_MRET   = 3'd5;

  localparam logic [1:0] RF_PC4 = 2'd0;
  localparam logic [1:0] RF_CSR = 2'd1;
  localparam logic [1:0] RF_MEM = 2'd2;
  localparam logic [1:0] RF_ALU = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [3:0] alu_fun;
    logic       mdu_op;
    logic [1:0] rf_wr_sel;
    logic [2:0] pcsource;
    logic       reg_write;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] msize;
    logic       msign;
    logic       illegal;
    logic       int_taken;
  } ctrl_t;

endpackage

// File: rtl/otter_decode_logic.sv
// Combinational RV32I(+M) field decoder producing the control bundle.
// Latency 0; no flow control of its own.
module otter_decode_logic
  import otter_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  output ctrl_t      ctrl,
  output logic       is_mret
);

  logic known;
  logic bad_f7;
  logic writes;
  logic muldiv;

  assign muldiv = EN_MEXT && (funct7 == F7_MULDIV);

  always_comb begin
    ctrl           = '0;
    ctrl.rf_wr_sel = RF_ALU;
    ctrl.pcsource  = PCS_PLUS4;
    ctrl.alu_fun   = ALU_ADD;
    is_mret        = 1'b0;
    known          = 1'b1;
    bad_f7         = 1'b0;
    writes         = 1'b0;
    case (opcode_t'(opcode))
      OPC_LUI: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_fun  = ALU_LUI;
        writes        = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = 2'd3;
        writes        = 1'b1;
      end
      OPC_JAL: begin
        ctrl.rf_wr_sel = RF_PC4;
        ctrl.pcsource  = PCS_JAL;
        writes         = 1'b1;
      end
      OPC_JALR: begin
        ctrl.alu_srcb  = 2'd1;
        ctrl.rf_wr_sel = RF_PC4;
        ctrl.pcsource  = PCS_JALR;
        writes         = 1'b1;
      end
      OPC_BRANCH: ctrl.pcsource = PCS_BRANCH;
      OPC_LOAD: begin
        ctrl.alu_srcb  = 2'd1;
        ctrl.rf_wr_sel = RF_MEM;
        ctrl.mem_re    = 1'b1;
        writes         = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_srcb = 2'd2;
        ctrl.mem_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_srcb = 2'd1;
        ctrl.alu_fun  = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
        writes        = 1'b1;
      end
      OPC_OP: begin
        ctrl.mdu_op  = muldiv;
        ctrl.alu_fun = muldiv ? {1'b0, funct3} : {funct7[5], funct3};
        bad_f7       = !((funct7 == F7_BASE) || (funct7 == F7_ALT) || muldiv);
        writes       = 1'b1;
      end
      OPC_SYSTEM: begin
        ctrl.alu_fun   = ALU_LUI;
        ctrl.rf_wr_sel = RF_CSR;
        if (funct3_system_t'(funct3) == F3_PRIV) begin
          ctrl.pcsource = PCS_MRET;
          is_mret       = 1'b1;
        end else begin
          writes = 1'b1;
        end
      end
      default: known = 1'b0;
    endcase
    ctrl.illegal   = (opcode[1:0] != 2'b11) || !known || bad_f7;
    // An illegal word must never commit side effects downstream.
    ctrl.reg_write = writes && (rd != 5'd0) && !ctrl.illegal;
    ctrl.mem_we    = ctrl.mem_we && !ctrl.illegal;
    ctrl.mem_re    = ctrl.mem_re && !ctrl.illegal;
    ctrl.msize     = funct3[1:0];
    ctrl.msign     = ~funct3[2];
  end

endmodule

// File: rtl/otter_decode_stage.sv
// Registered ID stage: decode into ID/EX register with interrupt injection and RUN/TRAP tracking.
// Latency 1 cycle; holds all outputs while OUT_VALID & ~OUT_READY, FLUSH squashes slot and input.
module otter_decode_stage
  import otter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_MEXT = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IR_IN,
  input  logic [XLEN-1:0]  PC_IN,
  input  logic             FLUSH,
  input  logic             INT_REQ,
  input  logic             CSR_MIE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  PC_OUT,
  output logic [31:0]      IR_OUT,
  output logic             ALU_SRCA,
  output logic [1:0]       ALU_SRCB,
  output logic [3:0]       ALU_FUN,
  output logic             MDU_OP,
  output logic [1:0]       RF_WR_SEL,
  output logic [2:0]       PCSOURCE,
  output logic             REG_WRITE,
  output logic             MEM_WE,
  output logic             MEM_RE,
  output logic [1:0]       MSIZE,
  output logic             MSIGN,
  output logic             ILLEGAL,
  output logic             INT_TAKEN,
  output logic             IN_TRAP,
  output logic [CNT_W-1:0] DEC_COUNT
);

  ctrl_t             dec_ctrl;
  ctrl_t             slot_ctrl;
  ctrl_t             ctl_q;
  logic              is_mret;
  logic              accept;
  logic              int_fire;
  logic              out_vld_q;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic [CNT_W-1:0]  cnt_q;
  trap_state_t       state_q;
  trap_state_t       state_d;

  otter_decode_logic #(.EN_MEXT(EN_MEXT)) u_decode (
    .opcode  (IR_IN[6:0]),
    .funct3  (IR_IN[14:12]),
    .funct7  (IR_IN[31:25]),
    .rd      (IR_IN[11:7]),
    .ctrl    (dec_ctrl),
    .is_mret (is_mret)
  );

  assign IN_READY = ~out_vld_q | OUT_READY;
  assign accept   = IN_VALID & IN_READY & ~FLUSH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept && INT_REQ && CSR_MIE) state_d = ST_TRAP;
      ST_TRAP: if (accept && is_mret) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    int_fire = accept && INT_REQ && CSR_MIE && (state_q == ST_RUN);
    IN_TRAP  = (state_q == ST_TRAP);
  end

  // Interrupt slot keeps the decoded fields (ILLEGAL included) but drops all side effects.
  always_comb begin
    slot_ctrl = dec_ctrl;
    if (int_fire) begin
      slot_ctrl.pcsource  = PCS_INTR;
      slot_ctrl.reg_write = 1'b0;
      slot_ctrl.mem_we    = 1'b0;
      slot_ctrl.mem_re    = 1'b0;
      slot_ctrl.int_taken = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_vld_q <= 1'b0;
      pc_q      <= '0;
      ir_q      <= '0;
      ctl_q     <= '0;
      cnt_q     <= '0;
    end else if (FLUSH) begin
      out_vld_q <= 1'b0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      pc_q      <= PC_IN;
      ir_q      <= IR_IN;
      ctl_q     <= slot_ctrl;
      cnt_q     <= cnt_q + CNT_W'(1);
    end else if (OUT_READY) begin
      out_vld_q <= 1'b0;
    end
  end

  assign OUT_VALID = out_vld_q;
  assign PC_OUT    = pc_q;
  assign IR_OUT    = ir_q;
  assign ALU_SRCA  = ctl_q.alu_srca;
  assign ALU_SRCB  = ctl_q.alu_srcb;
  assign ALU_FUN   = ctl_q.alu_fun;
  assign MDU_OP    = ctl_q.mdu_op;
  assign RF_WR_SEL = ctl_q.rf_wr_sel;
  assign PCSOURCE  = ctl_q.pcsource;
  assign REG_WRITE = ctl_q.reg_write;
  assign MEM_WE    = ctl_q.mem_we;
  assign MEM_RE    = ctl_q.mem_re;
  assign MSIZE     = ctl_q.msize;
  assign MSIGN     = ctl_q.msign;
  assign ILLEGAL   = ctl_q.illegal;
  assign INT_TAKEN = ctl_q.int_taken;
  assign DEC_COUNT = cnt_q;

endmodule

// File: doc/otter_decode_stage.md
Name: otter_decode_stage

Overview:
- Registered instruction-decode stage for the pipelined OTTER core; sits between the IF/ID register and execute.
- Decodes RV32I (+ optional M) control fields from the raw instruction word into an ID/EX pipeline register.
- Uses a valid/ready handshake, a flush, interrupt injection with a one-level trap state, and illegal-instruction detection.
- Successor to the combinational decoder: generalised to XLEN and M-extension mode, and adds sequential pipelining and trap tracking.

Parameters:
XLEN, 32, width of PC_IN/PC_OUT.
EN_MEXT, 1, when 1 decode OP with func7=0000001 as multiply/divide; when 0 treat it as illegal.
CNT_W, 32, width of the DEC_COUNT counter.

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  IR_IN/PC_IN valid
IN_READY  out  1  stage can accept
IR_IN  in  32  instruction word
PC_IN  in  XLEN  instruction PC
FLUSH  in  1  squash the register contents and this cycle's input
INT_REQ  in  1  level interrupt request
CSR_MIE  in  1  global interrupt enable
OUT_VALID  out  1  ID/EX register valid
OUT_READY  in  1  execute stage accepts
PC_OUT  out  XLEN  registered PC
IR_OUT  out  32  registered instruction
ALU_SRCA  out  1  ALU operand A select
ALU_SRCB  out  2  ALU operand B select
ALU_FUN  out  4  ALU function code
MDU_OP  out  1  multiply/divide operation
RF_WR_SEL  out  2  register-file write-data select
PCSOURCE  out  3  next-PC select
REG_WRITE  out  1  register-file write enable
MEM_WE  out  1  memory write enable
MEM_RE  out  1  memory read enable
MSIZE  out  2  IR[13:12]
MSIGN  out  1  ~IR[14]
ILLEGAL  out  1  illegal instruction
INT_TAKEN  out  1  slot is an injected interrupt
IN_TRAP  out  1  FSM is in TRAP
DEC_COUNT  out  CNT_W  count of accepted non-flushed slots

Behaviour:
Reset (RST_N=0, async):
- OUT_VALID=0.
- All registered control outputs, PC_OUT, IR_OUT and DEC_COUNT = 0.
- FSM = RUN.

Handshake:
- IN_READY = ~OUT_VALID | OUT_READY (combinational).
- Accept when IN_VALID & IN_READY & ~FLUSH; the register loads on the next edge. Latency is 1 cycle.
- If OUT_VALID & ~OUT_READY, every output holds stable.
- If OUT_READY and no accept, OUT_VALID <= 0.
- FLUSH has priority: OUT_VALID <= 0, the input that cycle is dropped, FSM and DEC_COUNT are unchanged.

Decode (on accepted IR; op=IR[6:0], f3=IR[14:12], f7=IR[31:25]):
- ALU_FUN:
  - OP: {f7[5],f3}.
  - OP_IMM: {f7[5],f3} if f3=101, else {0,f3}.
  - LUI and SYSTEM: 1001.
  - all others: 0000.
  - EN_MEXT and OP with f7=0000001: MDU_OP=1, ALU_FUN={0,f3}.
- ALU_SRCA = 1 for LUI/AUIPC, else 0.
- ALU_SRCB: STORE 2; LOAD/JALR/OP_IMM 1; AUIPC 3; else 0.
- RF_WR_SEL: JAL/JALR 0; SYSTEM 1; LOAD 2; else 3.
- PCSOURCE: JAL 3; JALR 1; BRANCH 2; SYSTEM with f3=000 (mret) 5; else 0.
- REG_WRITE = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and SYSTEM with f3≠000, and only when IR[11:7]≠0.
- MEM_WE = STORE; MEM_RE = LOAD.
- ILLEGAL = 1 when any of:
  - IR[1:0]≠11;
  - op not one of the ten base opcodes;
  - OP with f7 ∉ {0000000, 0100000, 0000001 if EN_MEXT}.
- If ILLEGAL: REG_WRITE=MEM_WE=MEM_RE=0.

FSM {RUN, TRAP}:
- RUN, accept & INT_REQ & CSR_MIE: the slot becomes an interrupt.
  - INT_TAKEN=1, PCSOURCE=100, REG_WRITE=MEM_WE=MEM_RE=0, PC_OUT=PC_IN.
  - FSM → TRAP.
- TRAP: interrupts are ignored. An accepted mret → RUN on the same edge.
- An interrupt also overrides an mret or an illegal instruction arriving in RUN (INT_TAKEN wins; ILLEGAL is still reported).
- FLUSH never changes FSM state.

DEC_COUNT:
- Increments on each accept, including interrupt slots.
- Wraps modulo 2^CNT_W.

Decomposition:
- Shared package otter_pkg holds:
  - opcode_t (ten opcodes);
  - funct3_system_t;
  - PCSOURCE constants (PC_PLUS4=0, JALR=1, BRANCH=2, JAL=3, INTR=4, MRET=5);
  - RF_WR_SEL constants;
  - ALU_FUN codes.
- One combinational sub-module otter_decode_logic maps IR to the control bundle. The top module holds the handshake, FSM, counter and register.

Test Plan:
- Handshake: reset, then ADD x3,x1,x2 (0x002081B3) with OUT_READY=1 → next cycle OUT_VALID=1, ALU_FUN=0000, ALU_SRCB=0, RF_WR_SEL=3, REG_WRITE=1, DEC_COUNT=1.
- Backpressure: OUT_READY=0 for 3 cycles with a second instruction offered → IN_READY=0 and outputs unchanged; release → second instruction appears 1 cycle later.
- Flush: FLUSH together with valid SRAI (0x4020D093) → OUT_VALID=0 next cycle, DEC_COUNT unchanged, no state change.
- Interrupt/trap: INT_REQ=1, CSR_MIE=1, then LW accepted → PCSOURCE=100, INT_TAKEN=1, MEM_RE=0, IN_TRAP=1. A second INT_REQ is ignored. mret (0x30200073) → PCSOURCE=101, IN_TRAP=0.
- Illegal and M-mode:
  - 0x00000000 → ILLEGAL=1, REG_WRITE=0.
  - MUL (0x022081B3) with EN_MEXT=1 → MDU_OP=1, ALU_FUN=0000.
  - MUL with EN_MEXT=0 → ILLEGAL=1.
- Async reset mid-stall: drop RST_N while OUT_VALID=1 and state is TRAP → outputs 0 immediately without waiting for CLK; state is RUN.
